// File: rtl/unary_pkg.sv
// Shared types for the unary accumulator array: controller states and default lane types.
// The lane typedefs describe the default configuration (WIDTH=8, ACC_WIDTH=16).
package unary_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_ACC_WIDTH = 2 * DEFAULT_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    ACCUM = 2'd2,
    OUT   = 2'd3
  } state_t;

  typedef logic signed [DEFAULT_WIDTH-1:0]     weight_t;
  typedef logic signed [DEFAULT_ACC_WIDTH-1:0] acc_t;

endpackage

// File: rtl/unary_accumulator_array_if.sv
// Result port of the unary accumulator array: per-lane sums, overflow and stream length.
// The producer holds every field stable while out_valid is high and out_ready is low.
interface unary_accumulator_array_if #(
  parameter int DIM       = 4,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2 * WIDTH
);

  logic                            out_valid;
  logic                            out_ready;
  logic [DIM-1:0][ACC_WIDTH-1:0]   acc_out;
  logic [DIM-1:0]                  overflow;
  logic [WIDTH-1:0]                stream_len;

  modport master (
    output out_valid, acc_out, overflow, stream_len,
    input  out_ready
  );

  modport slave (
    input  out_valid, acc_out, overflow, stream_len,
    output out_ready
  );

endinterface

// File: rtl/unary_mac_lane.sv
// One lane: captured signed weight, added or subtracted from a wrapping accumulator per unary bit.
// Single-cycle update; overflow is sticky until the next load.
module unary_mac_lane #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2 * WIDTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        load,
  input  logic                        en,
  input  logic [WIDTH-1:0]            weight,
  input  logic                        unary,
  input  logic                        neg,
  output logic signed [ACC_WIDTH-1:0] acc,
  output logic                        ovf
);

  logic signed [WIDTH-1:0]     w_q;
  logic signed [ACC_WIDTH-1:0] w_ext;
  logic signed [ACC_WIDTH-1:0] operand;
  logic signed [ACC_WIDTH-1:0] sum;
  logic                        step_ovf;

  // Extending before negation keeps -2^(WIDTH-1) representable when subtracted.
  always_comb begin
    w_ext    = {{(ACC_WIDTH-WIDTH){w_q[WIDTH-1]}}, w_q};
    operand  = neg ? -w_ext : w_ext;
    sum      = acc + operand;
    step_ovf = (acc[ACC_WIDTH-1] == operand[ACC_WIDTH-1]) &&
               (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      w_q <= weight;
      acc <= '0;
      ovf <= 1'b0;
    end else if (en && unary) begin
      acc <= sum;
      if (step_ovf) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/unary_accumulator_array.sv
// Multiplies DIM sign-magnitude unary streams by captured weights; result N+2 cycles after start.
// Result is held on a valid/ready port; start is ignored until the result is taken.
module unary_accumulator_array
  import unary_pkg::*;
#(
  parameter int DIM       = 4,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2 * WIDTH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [DIM-1:0][WIDTH-1:0]     weight,
  input  logic [DIM-1:0]                unary_in,
  input  logic [DIM-1:0]                neg_in,
  input  logic                          stream_done,
  output logic                          count_en,
  output logic                          busy,
  unary_accumulator_array_if.master     result
);

  state_t                        state;
  logic [WIDTH-1:0]              cycle_cnt;
  logic [WIDTH-1:0]              cnt_next;
  logic [DIM-1:0][ACC_WIDTH-1:0] acc;
  logic [DIM-1:0]                ovf;
  logic                          load;
  logic                          lane_en;

  assign load     = (state == IDLE) && start;
  // The done cycle carries no upstream contributions, so lanes sit still.
  assign lane_en  = (state == ACCUM) && !stream_done;
  assign cnt_next = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + WIDTH'(1);

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    unary_mac_lane #(
      .WIDTH     (WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .en      (lane_en),
      .weight  (weight[i]),
      .unary   (unary_in[i]),
      .neg     (neg_in[i]),
      .acc     (acc[i]),
      .ovf     (ovf[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      count_en          <= 1'b0;
      busy              <= 1'b0;
      cycle_cnt         <= '0;
      result.out_valid  <= 1'b0;
      result.acc_out    <= '0;
      result.overflow   <= '0;
      result.stream_len <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ARM;
            busy      <= 1'b1;
            cycle_cnt <= '0;
          end
        end
        ARM: begin
          state    <= ACCUM;
          count_en <= 1'b1;
        end
        ACCUM: begin
          cycle_cnt <= cnt_next;
          if (stream_done) begin
            state             <= OUT;
            count_en          <= 1'b0;
            result.out_valid  <= 1'b1;
            result.acc_out    <= acc;
            result.overflow   <= ovf;
            result.stream_len <= cnt_next;
          end
        end
        OUT: begin
          if (result.out_ready) begin
            state            <= IDLE;
            busy             <= 1'b0;
            result.out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
